// File: rtl/wb_pkg.sv
// wb_pkg: shared types and helpers for the write-back queue.
// Entry widths are fixed here; wb_queue checks that its DATA_W/ADDR_W agree.
package wb_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DEPTH  = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Register 0 is never written, so it never counts as a match.
    function automatic logic entry_match(input wb_entry_t entry,
                                         input logic [WB_ADDR_W-1:0] addr);
        return (addr != '0) && (entry.addr == addr);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: dual-push, single-pop circular buffer. Push 0 lands ahead of push 1.
// All slots, their valid mask and the read pointer are exposed for bypass search.
// The caller guarantees pushes never exceed free space.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push0_i,
    input  wb_entry_t                push0_entry_i,
    input  logic                     push1_i,
    input  wb_entry_t                push1_entry_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output wb_entry_t                entries_o [DEPTH],
    output logic [DEPTH-1:0]         valid_o,
    output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] slot1;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state for pointers, occupancy and valid mask; pointers wrap modulo DEPTH.
    always_comb begin
        slot1    = wr_ptr_q + PTR_W'(push0_i);
        wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
        valid_d  = valid_q;
        if (pop_i) valid_d[rd_ptr_q] = 1'b0;
        if (push0_i) valid_d[wr_ptr_q] = 1'b1;
        if (push1_i) valid_d[slot1] = 1'b1;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage; contents are qualified by valid_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push0_i) mem_q[wr_ptr_q] <= push0_entry_i;
            if (push1_i) mem_q[slot1] <= push1_entry_i;
        end
    end

    // Expose every slot for the bypass search.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            entries_o[k] = mem_q[k];
        end
    end

    assign head_o   = mem_q[rd_ptr_q];
    assign valid_o  = valid_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/wb_queue.sv
// wb_queue: write-back stage in front of the register file write port.
// Arbitrates memory-unit and ALU results into wb_fifo (memory first), retires
// one entry per cycle into a registered rf_* port.
// Optional feature macro: WB_QUEUE_BYPASS_EN enables the lk_* read-after-write
// bypass; when undefined lk_hit_n/lk_data_n are tied to zero.
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DEPTH  = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    input  logic [ADDR_W-1:0]      lk_addr_1,
    input  logic [ADDR_W-1:0]      lk_addr_2,
    output logic                   lk_hit_1,
    output logic [DATA_W-1:0]      lk_data_1,
    output logic                   lk_hit_2,
    output logic [DATA_W-1:0]      lk_data_2,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_FREE_C = CNT_W'(DEPTH - 1);

    // Entries are wb_pkg structs, so port widths must agree with the package.
    if (DATA_W != WB_DATA_W || ADDR_W != WB_ADDR_W) begin : g_width_check
        $error("wb_queue: DATA_W/ADDR_W must equal wb_pkg WB_DATA_W/WB_ADDR_W");
    end

    wb_entry_t        mem_entry, alu_entry, head_w;
    wb_entry_t        entries_w [DEPTH];
    logic [DEPTH-1:0] valid_w;
    logic [PTR_W-1:0] rd_ptr_w;
    logic             mem_fire, alu_fire, push_mem, push_alu, pop;
    logic             rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    // Readiness from the current count only; the memory unit is served first.
    always_comb begin
        mem_ready = (count < FULL_C);
        alu_ready = (count < ONE_FREE_C) || ((count == ONE_FREE_C) && !mem_valid);
        mem_fire  = mem_valid && mem_ready;
        alu_fire  = alu_valid && alu_ready;
        push_mem  = mem_fire && (mem_addr != '0);
        push_alu  = alu_fire && (alu_addr != '0);
        pop       = (count != '0);
    end

    assign mem_entry = '{addr: mem_addr, data: mem_data};
    assign alu_entry = '{addr: alu_addr, data: alu_data};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push0_i      (push_mem),
        .push0_entry_i(mem_entry),
        .push1_i      (push_alu),
        .push1_entry_i(alu_entry),
        .pop_i        (pop),
        .head_o       (head_w),
        .entries_o    (entries_w),
        .valid_o      (valid_w),
        .rd_ptr_o     (rd_ptr_w),
        .count_o      (count)
    );

    // Output register next state: pulse we for each pop, hold addr/data when idle.
    always_comb begin
        rf_we_d    = pop;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pop) begin
            rf_waddr_d = head_w.addr;
            rf_wdata_d = head_w.data;
        end
    end

    // Output register toward the regfile write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_QUEUE_BYPASS_EN
    wb_entry_t        out_entry;
    logic [PTR_W-1:0] slot;

    assign out_entry = '{addr: rf_waddr_q, data: rf_wdata_q};

    // Bypass search: output register is oldest, then head up to newest entry;
    // later matches overwrite earlier ones so the youngest value wins.
    always_comb begin
        lk_hit_1  = 1'b0;
        lk_data_1 = '0;
        lk_hit_2  = 1'b0;
        lk_data_2 = '0;
        slot      = '0;
        if (rf_we_q && entry_match(out_entry, lk_addr_1)) begin
            lk_hit_1  = 1'b1;
            lk_data_1 = rf_wdata_q;
        end
        if (rf_we_q && entry_match(out_entry, lk_addr_2)) begin
            lk_hit_2  = 1'b1;
            lk_data_2 = rf_wdata_q;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_w + PTR_W'(k);
            if (valid_w[slot] && entry_match(entries_w[slot], lk_addr_1)) begin
                lk_hit_1  = 1'b1;
                lk_data_1 = entries_w[slot].data;
            end
            if (valid_w[slot] && entry_match(entries_w[slot], lk_addr_2)) begin
                lk_hit_2  = 1'b1;
                lk_data_2 = entries_w[slot].data;
            end
        end
    end
`else
    logic unused_bypass;

    assign lk_hit_1  = 1'b0;
    assign lk_data_1 = '0;
    assign lk_hit_2  = 1'b0;
    assign lk_data_2 = '0;

    // Bypass disabled: fold the otherwise unused lookup inputs and fifo taps.
    always_comb begin
        unused_bypass = ^{lk_addr_1, lk_addr_2, valid_w, rd_ptr_w};
        for (int unsigned k = 0; k < DEPTH; k++) begin
            unused_bypass = unused_bypass ^ (^entries_w[k]);
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed stimulus with a write scoreboard for wb_queue.
// Accepted results are queued as expected regfile writes; a negedge monitor
// pops and compares whenever rf_we is high.
module tb_wb_queue;

    localparam int DEPTH = 4;
`ifdef WB_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ready, alu_valid, alu_ready;
    logic [4:0]  mem_addr, alu_addr;
    logic [31:0] mem_data, alu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  lk_addr_1, lk_addr_2;
    logic        lk_hit_1, lk_hit_2;
    logic [31:0] lk_data_1, lk_data_2;
    logic [2:0]  count;

    wb_queue #(
        .DATA_W(32),
        .ADDR_W(5),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_addr (alu_addr),
        .alu_data (alu_data),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .lk_addr_1(lk_addr_1),
        .lk_addr_2(lk_addr_2),
        .lk_hit_1 (lk_hit_1),
        .lk_data_1(lk_data_1),
        .lk_hit_2 (lk_hit_2),
        .lk_data_2(lk_data_2),
        .count    (count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [36:0] exp_q[$];
    int          mc = 0;
    logic        exp_we = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every regfile write must match the oldest expected write.
    always @(negedge clk) begin : monitor
        logic [36:0] e;
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL write_unexpected: got r%0d<=0x%0h, expected no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write", 64'({rf_waddr, rf_wdata}), 64'(e));
            end
        end
    end

    // One cycle: drive at posedge+1, check at posedge+4, update model, wait next edge.
    task automatic step(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad);
        int   free;
        logic emr, ear;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        #3;
        free = DEPTH - mc;
        emr  = (free >= 1);
        ear  = (free >= 2) || (free == 1 && !mv);
        chk("count", 64'(count), 64'(mc));
        chk("rf_we", 64'(rf_we), 64'(exp_we));
        chk("mem_ready", 64'(mem_ready), 64'(emr));
        chk("alu_ready", 64'(alu_ready), 64'(ear));
        if (mv && emr && ma != 5'd0) begin exp_q.push_back({ma, md}); mc++; end
        if (av && ear && aa != 5'd0) begin exp_q.push_back({aa, ad}); mc++; end
        exp_we = (free != DEPTH);
        if (free != DEPTH) mc--;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mc = 0;
        exp_we = 1'b0;
        exp_q.delete();
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
    endtask

    // Bounded drain; a leftover expected write is a failure.
    task automatic drain();
        for (int i = 0; i < 12 && (mc != 0 || exp_q.size() != 0); i++) idle();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic lkchk(input string tag, input logic h1, input logic [31:0] d1);
        chk({tag, "_hit1"}, 64'(lk_hit_1), 64'(BYP ? h1 : 1'b0));
        chk({tag, "_data1"}, 64'(lk_data_1), 64'(BYP ? d1 : 32'd0));
        chk({tag, "_hit2"}, 64'(lk_hit_2), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lk_addr_1 = '0; lk_addr_2 = '0;
        @(posedge clk);
        do_reset();

        // 1: idle after reset
        repeat (10) idle();

        // 2: single ALU push, one-cycle write pulse
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF);
        idle();
        chk("t2_waddr", 64'(rf_waddr), 64'd3);
        chk("t2_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        idle();
        drain();

        // 3: same-cycle mem and alu to r5, mem retires first
        step(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        drain();

        // 4: saturate both producers, then ALU alone at free==1
        for (int i = 0; i < 8; i++)
            step(1'b1, 5'(8 + i), 32'h100 + 32'(i), 1'b1, 5'(16 + i), 32'h200 + 32'(i));
        chk("t4_count_sat", 64'(count), 64'd3);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'hABC);
        drain();

        // 5: address-0 results are accepted but never written
        step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        idle();
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd9, 32'h99);
        drain();

        // 6: reset with three pending entries discards them
        step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hA1);
        step(1'b1, 5'd12, 32'hA2, 1'b1, 5'd13, 32'hA3);
        chk("t6_count_before", 64'(count), 64'd3);
        do_reset();
        repeat (6) idle();

        // 7: bypass lookup of pending r7 values
        lk_addr_1 = 5'd7;
        lk_addr_2 = 5'd0;
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        lkchk("t7_q2", 1'b1, 32'h2);
        idle();
        lkchk("t7_q1", 1'b1, 32'h2);
        idle();
        lkchk("t7_out", 1'b1, 32'h2);
        idle();
        chk("t7_none_hit1", 64'(lk_hit_1), 64'd0);
        drain();

        chk("final_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
